// File: rtl/matrix2x2_host.sv
// rtl/matrix2x2_host.sv - stream-side initiator for the 2x2 packed-byte matrix multiplier
// Loads A then B element by element, launches the multiplier and streams the result back.
module matrix2x2_host #(
  parameter int ELEM_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ELEM_W-1:0]   in_data,
  output logic [4*ELEM_W-1:0] mat_a,
  output logic [4*ELEM_W-1:0] mat_b,
  output logic                mat_start,
  input  logic                mat_done,
  input  logic [4*ELEM_W-1:0] mat_res,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ELEM_W-1:0]   out_data,
  output logic                err,
  output logic                busy
);

  localparam int W  = 4 * ELEM_W;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {LOAD, START, WAIT, SEND} state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [1:0]    oidx;
  logic [CW-1:0] cnt;
  logic [W-1:0]  res;

  // Element 0 of a packed word sits in the most significant slot.
  function automatic logic [ELEM_W-1:0] elem_of(input logic [W-1:0] word, input logic [1:0] pos);
    elem_of = word[(3 - int'(pos)) * ELEM_W +: ELEM_W];
  endfunction

  assign in_ready = (state == LOAD);
  assign busy     = (state != LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      idx       <= '0;
      oidx      <= '0;
      cnt       <= '0;
      res       <= '0;
      mat_a     <= '0;
      mat_b     <= '0;
      mat_start <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            err <= 1'b0;
            if (!idx[2]) mat_a[(3 - int'(idx[1:0])) * ELEM_W +: ELEM_W] <= in_data;
            else         mat_b[(3 - int'(idx[1:0])) * ELEM_W +: ELEM_W] <= in_data;
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
              state     <= START;
              mat_start <= 1'b1;
            end
          end
        end
        START: begin
          mat_start <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // A response on the final allowed cycle still counts as success.
          if (mat_done) begin
            res       <= mat_res;
            cnt       <= '0;
            oidx      <= 2'd0;
            out_valid <= 1'b1;
            out_data  <= elem_of(mat_res, 2'd0);
            state     <= SEND;
          end else if (cnt == CNT_LAST) begin
            err   <= 1'b1;
            cnt   <= '0;
            idx   <= '0;
            state <= LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (oidx == 2'd3) begin
              out_valid <= 1'b0;
              idx       <= '0;
              state     <= LOAD;
            end else begin
              oidx     <= oidx + 2'd1;
              out_data <= elem_of(res, oidx + 2'd1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: doc/matrix2x2_host.md
Name: matrix2x2_host

Overview:
- Stream-side initiator for the team's 2x2 packed-byte matrix multiplier.
- Accepts eight 8-bit elements one at a time over a valid/ready input stream: four for A, then four for B, row-major.
- Packs them into two 32-bit operand words, launches the multiplier and waits for its result.
- Returns the four result elements one at a time over a valid/ready output stream, with a watchdog on the multiplier response.

Parameters:
ELEM_W, 8, element width in bits; operand and result words are 4*ELEM_W.
TIMEOUT, 64, maximum cycles in WAIT before a missing mat_done is flagged; must be >= 1.

Ports:
clk  input  1  clock; all state changes on its rising edge.
rst  input  1  reset, asynchronous and active-high.
in_valid  input  1  input element present.
in_ready  output  1  host can accept an element; combinational, equals (state==LOAD).
in_data  input  ELEM_W  input element.
mat_a  output  4*ELEM_W  packed A: [31:24]=a00, [23:16]=a01, [15:8]=a10, [7:0]=a11.
mat_b  output  4*ELEM_W  packed B, same packing.
mat_start  output  1  one-cycle launch pulse to the multiplier.
mat_done  input  1  multiplier result valid; sampled only in WAIT.
mat_res  input  4*ELEM_W  packed result, same packing.
out_valid  output  1  output element present.
out_ready  input  1  downstream accepts the output element.
out_data  output  ELEM_W  output element.
err  output  1  sticky timeout flag.
busy  output  1  high in every state except LOAD.

Behaviour:
- Reset (async, active-high):
  - state=LOAD, element index=0, wait counter=0.
  - mat_a=0, mat_b=0, mat_start=0, out_valid=0, out_data=0, err=0, result register=0.
  - Reset asserted mid-operation aborts immediately: out_valid and mat_start drop with rst, and partial loads are discarded.
- States: LOAD, START, WAIT, SEND.
- LOAD:
  - A transfer occurs on an edge where in_valid & in_ready are both high.
  - Index 0..3 writes mat_a bytes in order a00, a01, a10, a11 (index 0 lands in [31:24]).
  - Index 4..7 writes mat_b bytes in the same order.
  - in_valid low stalls without changing the index.
  - The transfer at index 7 moves to START.
  - Any accepted element clears err.
- START: mat_start=1 for exactly this one cycle; go to WAIT. mat_a and mat_b are held stable from START until the next LOAD transfer.
- WAIT:
  - Counter increments each cycle.
  - If mat_done=1: capture mat_res, go to SEND, clear counter.
  - Else if counter reaches TIMEOUT-1: set err=1, clear counter, index=0, go to LOAD; no output is produced.
  - mat_done and timeout on the same edge: mat_done wins.
  - mat_done outside WAIT is ignored.
- SEND:
  - out_valid=1 with out_data = result byte at the output index, in order res[31:24], [23:16], [15:8], [7:0].
  - out_data is stable while out_valid & ~out_ready.
  - The 4th transfer clears out_valid on that edge and returns to LOAD with index=0; in_ready is high the next cycle.
- Latency, zero stalls, multiplier done D cycles after the start pulse:
  - Edge k accepts element 7; mat_start is high in cycle k+1.
  - The first out_valid appears in the cycle after the edge that samples mat_done.
- Arithmetic: the block does no arithmetic; only packing and unpacking. Widths scale with ELEM_W.

Test Plan:
1. Basic: feed 1,2,3,4,5,6,7,8 back-to-back; bench responder raises mat_done 3 cycles after mat_start with mat_res=0x13162B32.
   - Required: mat_a=0x01020304, mat_b=0x05060708, a single-cycle mat_start.
   - Required: out stream 0x13,0x16,0x2B,0x32; busy returns low after the last transfer.
2. Input gaps: same data with in_valid low for 2 cycles between every element.
   - Required: identical mat_a, mat_b and output; mat_start fires only after the 8th transfer.
3. Backpressure: out_ready toggles 1,0,0,1,...
   - Required: out_data is held while stalled; exactly 4 transfers in order; no duplicated or skipped byte.
4. Timeout with TIMEOUT=16: responder never raises mat_done.
   - Required: err=1 after 16 WAIT cycles, out_valid never asserted, in_ready=1.
   - Required: the next accepted element clears err, and a full second run produces correct output.
5. Same-edge race with TIMEOUT=16: mat_done asserted on the 16th WAIT cycle with mat_res=0xFFFFFFFF.
   - Required: err stays 0; output is 0xFF x4.
6. Async reset: assert rst mid-SEND after 2 transfers, between clock edges.
   - Required: out_valid=0, err=0 and mat_a=0 immediately.
   - Required: after release, in_ready=1, and a fresh 8-element run produces correct output.
